lsu_mem_ctrl: RTL and testbench

Sequencer between the Execute-stage load/store datapath and the data memory port. It accepts one load or store per handshake, places store bytes onto memory lanes and generates byte masks. It drives a request/grant/rvalid memory protocol with variable latency and returns sign- or zero-extended load data. When enabled, it splits word-crossing misaligned accesses into two memory beats. It holds the pipeline stalled while a transaction is in flight.

---
 rtl/lsu_pkg.sv | 32 +++
 rtl/lsu_lane_align.sv | 39 +++
 rtl/lsu_mem_ctrl.sv | 156 +++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store memory sequencer.
package lsu_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned MASK_W = DATA_W / 8;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE} state_t;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [MASK_W-1:0] mask;
   } lane_t;

   // Access size in bytes from the low two fun3 bits.
   function automatic logic [2:0] size_bytes(input logic [1:0] sz);
      case (sz)
         2'b00:   return 3'd1;
         2'b01:   return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Store lane placement / byte masks and load shift / extension, shared by both beats.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [2:0]          fun3,
   input  logic [1:0]          offset,
   input  logic                hi_beat,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [2*DATA_W-1:0] rword,
   output lane_t               lane,
   output logic [DATA_W-1:0]   rext
);

   logic [2:0]          size;
   logic [4:0]          shamt;
   logic [2*MASK_W-1:0] mask_wide;
   logic [2*DATA_W-1:0] wdata_wide;
   logic [DATA_W-1:0]   rsh;

   // Placement is done in a double-width window; the upper half is the spill into beat 1.
   always_comb begin
      size       = size_bytes(fun3[1:0]);
      shamt      = {offset, 3'b000};
      mask_wide  = ((8'd1 << size) - 8'd1) << offset;
      wdata_wide = {{DATA_W{1'b0}}, wdata} << shamt;
      lane.data  = hi_beat ? wdata_wide[2*DATA_W-1:DATA_W] : wdata_wide[DATA_W-1:0];
      lane.mask  = hi_beat ? mask_wide[2*MASK_W-1:MASK_W] : mask_wide[MASK_W-1:0];
      rsh        = DATA_W'(rword >> shamt);
      case (fun3)
         F3_LB:   rext = {{24{rsh[7]}}, rsh[7:0]};
         F3_LH:   rext = {{16{rsh[15]}}, rsh[15:0]};
         F3_LBU:  rext = {24'd0, rsh[7:0]};
         F3_LHU:  rext = {16'd0, rsh[15:0]};
         F3_LW:   rext = rsh;
         default: rext = rsh;
      endcase
   end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer between Execute and the req/gnt/rvalid data memory port.
// Define LSU_MISALIGN_SPLIT_EN to split word-crossing accesses into two beats.
module lsu_mem_ctrl
   import lsu_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_store,
   input  logic [2:0]        req_fun3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              stall,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [MASK_W-1:0] mem_mask,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata
);

   state_t            state, state_nx;
   logic [6:0]        op_q;
   logic [2:0]        f3_q;
   logic [1:0]        off_q;
   logic [DATA_W-1:0] wdata_q, rlo_q;
   logic              split_q;

   logic              is_store, accept, cross_c, illegal_c, split_c, err_c;
   logic              load_done_c, to_req1_c, idle;
   logic [2:0]        al_f3;
   logic [1:0]        al_off;
   logic [DATA_W-1:0] al_wdata, al_rext;
   logic [2*DATA_W-1:0] al_rword;
   lane_t             al_lane;

   assign idle     = (state == IDLE);
   assign is_store = (op_q == OP_STORE);
   assign accept   = req_valid && idle;

   // Legality and word-crossing decode of the incoming request.
   always_comb begin
      cross_c   = (3'(req_addr[1:0]) + size_bytes(req_fun3[1:0])) > 3'd4;
      illegal_c = (req_fun3 == 3'b011) || (req_fun3[2:1] == 2'b11) || (req_store && req_fun3[2]);
`ifdef LSU_MISALIGN_SPLIT_EN
      split_c   = cross_c;
      err_c     = illegal_c;
`else
      split_c   = 1'b0;
      err_c     = illegal_c || cross_c;
`endif
   end

   // In IDLE the aligner sees the live request (beat 0); afterwards the captured one (beat 1).
   always_comb begin
      al_f3    = idle ? req_fun3 : f3_q;
      al_off   = idle ? req_addr[1:0] : off_q;
      al_wdata = idle ? req_wdata : wdata_q;
      al_rword = (state == WAIT1) ? {mem_rdata, rlo_q} : {{DATA_W{1'b0}}, mem_rdata};
   end

   lsu_lane_align u_align (
      .fun3    (al_f3),
      .offset  (al_off),
      .hi_beat (!idle),
      .wdata   (al_wdata),
      .rword   (al_rword),
      .lane    (al_lane),
      .rext    (al_rext)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (accept)     state_nx = err_c ? DONE : REQ0;
         REQ0:  if (mem_gnt)    state_nx = !is_store ? WAIT0 : (split_q ? REQ1 : DONE);
         WAIT0: if (mem_rvalid) state_nx = split_q ? REQ1 : DONE;
         REQ1:  if (mem_gnt)    state_nx = is_store ? DONE : WAIT1;
         WAIT1: if (mem_rvalid) state_nx = DONE;
         DONE:                  state_nx = IDLE;
         default:               state_nx = IDLE;
      endcase
   end

   always_comb begin
      req_ready = 1'b0;
      mem_req   = 1'b0;
      rsp_valid = 1'b0;
      stall     = 1'b1;
      case (state)
         IDLE:       begin req_ready = 1'b1; stall = 1'b0; end
         REQ0, REQ1: mem_req   = 1'b1;
         DONE:       rsp_valid = 1'b1;
         default:    ;
      endcase
   end

   assign load_done_c = mem_rvalid && ((state == WAIT1) || ((state == WAIT0) && !split_q));
   assign to_req1_c   = (state_nx == REQ1) && (state != REQ1);

   // Request capture, beat payloads and response data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q      <= OP_LOAD;
         f3_q      <= 3'd0;
         off_q     <= 2'd0;
         wdata_q   <= '0;
         rlo_q     <= '0;
         split_q   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_mask  <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         if (accept) begin
            op_q      <= req_store ? OP_STORE : OP_LOAD;
            f3_q      <= req_fun3;
            off_q     <= req_addr[1:0];
            wdata_q   <= req_wdata;
            split_q   <= split_c;
            rsp_err   <= err_c;
            rsp_rdata <= '0;
            if (!err_c) begin
               mem_we    <= req_store;
               mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
               mem_wdata <= al_lane.data;
               mem_mask  <= al_lane.mask;
            end
         end
         if (to_req1_c) begin
            mem_addr  <= mem_addr + ADDR_W'(4);
            mem_wdata <= al_lane.data;
            mem_mask  <= al_lane.mask;
         end
         if ((state == WAIT0) && mem_rvalid) rlo_q <= mem_rdata;
         if (load_done_c) rsp_rdata <= al_rext;
         if (state == DONE) rsp_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed, table-driven bench for lsu_mem_ctrl with a grant/rvalid delay memory responder.
module tb_lsu_mem_ctrl;
   import lsu_pkg::*;

   logic        clk, rst_n;
   logic        req_valid, req_ready, req_store;
   logic [2:0]  req_fun3;
   logic [31:0] req_addr, req_wdata;
   logic        stall, rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic        mem_req, mem_we, mem_gnt, mem_rvalid;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_mask;

   lsu_mem_ctrl #(.ADDR_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
      .req_fun3(req_fun3), .req_addr(req_addr), .req_wdata(req_wdata),
      .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_mask(mem_mask), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Responder configuration (written by the stimulus process only).
   int          gnt_dly = 0;
   int          rv_dly  = 0;
   logic [31:0] word0 = '0, word1 = '0;

   // Responder state (written by the responder process only).
   int          wait_cnt = 0, pend = 0, rd_cnt = 0, beats = 0, req_cycles = 0, unstable = 0;
   logic [31:0] hold_addr = '0, hold_wdata = '0;
   logic [3:0]  hold_mask = '0;
   logic [31:0] log_addr [2];
   logic [31:0] log_wdata [2];
   logic [3:0]  log_mask [2];

   initial begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
   end

   always @(negedge clk) begin
      mem_rvalid = 1'b0;
      mem_gnt    = 1'b0;
      if (pend > 0) begin
         pend = pend - 1;
         if (pend == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = (rd_cnt == 0) ? word0 : word1;
            rd_cnt     = rd_cnt + 1;
         end
      end
      if (req_ready) begin
         beats = 0; wait_cnt = 0; rd_cnt = 0; req_cycles = 0; unstable = 0;
      end else if (mem_req) begin
         req_cycles = req_cycles + 1;
         if (wait_cnt == 0) begin
            hold_addr = mem_addr; hold_wdata = mem_wdata; hold_mask = mem_mask;
         end else if (hold_addr !== mem_addr || hold_wdata !== mem_wdata || hold_mask !== mem_mask) begin
            unstable = unstable + 1;
         end
         if (wait_cnt == gnt_dly) begin
            mem_gnt  = 1'b1;
            wait_cnt = 0;
            if (beats < 2) begin
               log_addr[beats] = mem_addr; log_wdata[beats] = mem_wdata; log_mask[beats] = mem_mask;
            end
            beats = beats + 1;
            if (!mem_we) pend = rv_dly + 1;
         end else begin
            wait_cnt = wait_cnt + 1;
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic        st;
      logic [2:0]  f3;
      logic [31:0] addr, wdata;
      int          gd, rd;
      logic [31:0] w0, w1, ex_rdata;
      logic        ex_err;
      int          ex_lat, ex_beats;
      logic [31:0] a0, d0, a1, d1;
      logic [3:0]  m0, m1;
   } vec_t;

   function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input int gd, input int rd,
                               input logic [31:0] w0, input logic [31:0] w1,
                               input logic [31:0] ex_rdata, input logic ex_err, input int ex_lat,
                               input int ex_beats, input logic [31:0] a0, input logic [3:0] m0,
                               input logic [31:0] d0, input logic [31:0] a1, input logic [3:0] m1,
                               input logic [31:0] d1);
      vec_t v;
      v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.gd = gd; v.rd = rd;
      v.w0 = w0; v.w1 = w1; v.ex_rdata = ex_rdata; v.ex_err = ex_err; v.ex_lat = ex_lat;
      v.ex_beats = ex_beats; v.a0 = a0; v.m0 = m0; v.d0 = d0; v.a1 = a1; v.m1 = m1; v.d1 = d1;
      return v;
   endfunction

   task automatic run_vec(input vec_t v, input int idx);
      int          lat;
      logic        got;
      logic [31:0] rd;
      logic        er;
      gnt_dly = v.gd; rv_dly = v.rd; word0 = v.w0; word1 = v.w1;
      check($sformatf("v%0d_ready", idx), 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_store = v.st; req_fun3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0; got = 1'b0; rd = '0; er = 1'b0;
      while (!got && lat < 40) begin
         @(negedge clk);
         lat++;
         if (rsp_valid) begin got = 1'b1; rd = rsp_rdata; er = rsp_err; end
      end
      if (!got) begin
         n_cmp++; n_bad++;
         $display("FAIL v%0d_timeout: got no rsp_valid expected one within 40 cycles", idx);
         return;
      end
      check($sformatf("v%0d_rdata", idx), rd, v.ex_rdata);
      check($sformatf("v%0d_err", idx), 32'(er), 32'(v.ex_err));
      check($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.ex_lat));
      check($sformatf("v%0d_beats", idx), 32'(beats), 32'(v.ex_beats));
      if (v.ex_beats >= 1) begin
         check($sformatf("v%0d_addr0", idx), log_addr[0], v.a0);
         check($sformatf("v%0d_mask0", idx), 32'(log_mask[0]), 32'(v.m0));
         if (v.st) check($sformatf("v%0d_wdata0", idx), log_wdata[0], v.d0);
         check($sformatf("v%0d_stable", idx), 32'(unstable), 32'd0);
         check($sformatf("v%0d_req_cycles", idx), 32'(req_cycles), 32'(v.ex_beats * (v.gd + 1)));
      end
      if (v.ex_beats == 2) begin
         check($sformatf("v%0d_addr1", idx), log_addr[1], v.a1);
         check($sformatf("v%0d_mask1", idx), 32'(log_mask[1]), 32'(v.m1));
         if (v.st) check($sformatf("v%0d_wdata1", idx), log_wdata[1], v.d1);
      end
      @(negedge clk);
      check($sformatf("v%0d_pulse", idx), {30'd0, rsp_valid, req_ready}, 32'd1);
   endtask

   vec_t vecs[$];
   logic seen_rsp, seen_req;

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_fun3 = '0; req_addr = '0; req_wdata = '0;

      //      st  f3         addr          wdata         gd rd w0            w1            rdata         er lat bt a0            m0     d0            a1            m1     d1
      vecs.push_back(mk(1, F3_LW,  32'h100,      32'hDEADBEEF, 0, 0, 32'h0,        32'h0,        32'h0,        0, 2, 1, 32'h100,      4'hF, 32'hDEADBEEF, 32'h0,   4'h0, 32'h0));
      vecs.push_back(mk(0, F3_LB,  32'h103,      32'h0,        0, 0, 32'h80FF0000, 32'h0,        32'hFFFFFF80, 0, 3, 1, 32'h100,      4'h8, 32'h0,        32'h0,   4'h0, 32'h0));
      vecs.push_back(mk(0, F3_LBU, 32'h103,      32'h0,        0, 0, 32'h80FF0000, 32'h0,        32'h00000080, 0, 3, 1, 32'h100,      4'h8, 32'h0,        32'h0,   4'h0, 32'h0));
      vecs.push_back(mk(1, F3_LH,  32'h102,      32'h00001234, 3, 0, 32'h0,        32'h0,        32'h0,        0, 5, 1, 32'h100,      4'hC, 32'h12340000, 32'h0,   4'h0, 32'h0));
      vecs.push_back(mk(0, F3_LH,  32'h102,      32'h0,        0, 0, 32'h80017777, 32'h0,        32'hFFFF8001, 0, 3, 1, 32'h100,      4'hC, 32'h0,        32'h0,   4'h0, 32'h0));
      vecs.push_back(mk(0, F3_LHU, 32'h102,      32'h0,        0, 2, 32'h80017777, 32'h0,        32'h00008001, 0, 5, 1, 32'h100,      4'hC, 32'h0,        32'h0,   4'h0, 32'h0));
      vecs.push_back(mk(0, F3_LW,  32'h104,      32'h0,        1, 1, 32'h12345678, 32'h0,        32'h12345678, 0, 5, 1, 32'h104,      4'hF, 32'h0,        32'h0,   4'h0, 32'h0));
      vecs.push_back(mk(1, F3_LB,  32'h101,      32'hFFFFFFA5, 0, 0, 32'h0,        32'h0,        32'h0,        0, 2, 1, 32'h100,      4'h2, 32'hFFFFA500, 32'h0,   4'h0, 32'h0));
      vecs.push_back(mk(0, 3'b011, 32'h100,      32'h0,        0, 0, 32'h0,        32'h0,        32'h0,        1, 1, 0, 32'h0,        4'h0, 32'h0,        32'h0,   4'h0, 32'h0));
      vecs.push_back(mk(1, F3_LBU, 32'h100,      32'h55,       0, 0, 32'h0,        32'h0,        32'h0,        1, 1, 0, 32'h0,        4'h0, 32'h0,        32'h0,   4'h0, 32'h0));
      vecs.push_back(mk(0, 3'b110, 32'h100,      32'h0,        0, 0, 32'h0,        32'h0,        32'h0,        1, 1, 0, 32'h0,        4'h0, 32'h0,        32'h0,   4'h0, 32'h0));
      vecs.push_back(mk(0, F3_LH,  32'h101,      32'h0,        0, 0, 32'h00ABCD00, 32'h0,        32'hFFFFABCD, 0, 3, 1, 32'h100,      4'h6, 32'h0,        32'h0,   4'h0, 32'h0));
      vecs.push_back(mk(1, F3_LH,  32'h101,      32'h0000BEEF, 0, 0, 32'h0,        32'h0,        32'h0,        0, 2, 1, 32'h100,      4'h6, 32'h00BEEF00, 32'h0,   4'h0, 32'h0));
`ifdef LSU_MISALIGN_SPLIT_EN
      vecs.push_back(mk(0, F3_LW,  32'hFFFFFFFE, 32'h0,        0, 0, 32'hAABB0000, 32'h0000CCDD, 32'hCCDDAABB, 0, 5, 2, 32'hFFFFFFFC, 4'hC, 32'h0,        32'h0,   4'h3, 32'h0));
      vecs.push_back(mk(1, F3_LW,  32'h103,      32'h11223344, 1, 0, 32'h0,        32'h0,        32'h0,        0, 5, 2, 32'h100,      4'h8, 32'h44000000, 32'h104, 4'h7, 32'h00112233));
      vecs.push_back(mk(0, F3_LH,  32'h103,      32'h0,        0, 0, 32'h11000000, 32'h00000022, 32'h00002211, 0, 5, 2, 32'h100,      4'h8, 32'h0,        32'h104, 4'h1, 32'h0));
`else
      vecs.push_back(mk(0, F3_LW,  32'hFFFFFFFE, 32'h0,        0, 0, 32'hAABB0000, 32'h0000CCDD, 32'h0,        1, 1, 0, 32'h0,        4'h0, 32'h0,        32'h0,   4'h0, 32'h0));
      vecs.push_back(mk(1, F3_LW,  32'h103,      32'h11223344, 1, 0, 32'h0,        32'h0,        32'h0,        1, 1, 0, 32'h0,        4'h0, 32'h0,        32'h0,   4'h0, 32'h0));
      vecs.push_back(mk(0, F3_LH,  32'h103,      32'h0,        0, 0, 32'h11000000, 32'h00000022, 32'h0,        1, 1, 0, 32'h0,        4'h0, 32'h0,        32'h0,   4'h0, 32'h0));
`endif

      // Reset state.
      #12;
      check("rst_ready_stall_req", {28'd0, req_ready, stall, mem_req, mem_we}, 32'h8);
      check("rst_rsp", {30'd0, rsp_valid, rsp_err}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_mem_mask", 32'(mem_mask), 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      foreach (vecs[i]) run_vec(vecs[i], i);

      // Reset while a load waits for rvalid; the late rvalid must be ignored.
      gnt_dly = 0; rv_dly = 8; word0 = 32'hCAFEF00D;
      req_valid = 1'b1; req_store = 1'b0; req_fun3 = F3_LW; req_addr = 32'h200; req_wdata = '0;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check("mrst_req0", {30'd0, mem_req, stall}, 32'd3);
      @(negedge clk);
      check("mrst_wait0", {30'd0, mem_req, stall}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("mrst_async", {29'd0, mem_req, req_ready, stall}, 32'd2);
      @(negedge clk);
      rst_n = 1'b1;
      seen_rsp = 1'b0; seen_req = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         seen_rsp |= rsp_valid;
         seen_req |= mem_req;
      end
      check("mrst_no_rsp", {30'd0, seen_rsp, seen_req}, 32'd0);
      check("mrst_idle", 32'(req_ready), 32'd1);

      // Controller still works after the mid-transaction reset.
      run_vec(mk(0, F3_LB, 32'h202, 32'h0, 0, 0, 32'h00330000, 32'h0, 32'h00000033, 0, 3, 1,
                 32'h200, 4'h4, 32'h0, 32'h0, 4'h0, 32'h0), 99);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
